// File: rtl/register_read_pkg.sv
// Shared types and constants for the register-read stage.
package register_read_pkg;
    localparam int XLEN      = 64;
    localparam int REG_NUM_W = 5;
    localparam int NUM_REGS  = 32;
    localparam int OP_W      = 11;

    localparam logic [6:0] OPC_OP_IMM    = 7'h13;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'h1b;
    localparam logic [6:0] OPC_LOAD      = 7'h03;
    localparam logic [6:0] OPC_JALR      = 7'h67;
    localparam logic [6:0] OPC_STORE     = 7'h23;
    localparam logic [6:0] OPC_BRANCH    = 7'h63;
    localparam logic [6:0] OPC_JAL       = 7'h6f;
    localparam logic [6:0] OPC_LUI       = 7'h37;
    localparam logic [6:0] OPC_AUIPC     = 7'h17;
    localparam logic [6:0] OPC_OP        = 7'h33;
    localparam logic [6:0] OPC_OP_32     = 7'h3b;
    localparam logic [6:0] OPC_SYSTEM    = 7'h73;

    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_SHAMT, IMM_NONE
    } imm_kind_e;

    // Shift-immediate forms (funct3 1/5) keep only the shift amount.
    function automatic imm_kind_e imm_kind(input logic [31:0] instrux);
        imm_kind_e k;
        case (instrux[6:0])
            OPC_OP_IMM, OPC_OP_IMM_32:
                k = (instrux[14:12] == 3'd1 || instrux[14:12] == 3'd5) ? IMM_SHAMT : IMM_I;
            OPC_LOAD, OPC_JALR: k = IMM_I;
            OPC_STORE:          k = IMM_S;
            OPC_BRANCH:         k = IMM_B;
            OPC_JAL:            k = IMM_J;
            OPC_LUI, OPC_AUIPC: k = IMM_U;
            default:            k = IMM_NONE;
        endcase
        return k;
    endfunction
endpackage

// File: rtl/register_read_regfile.sv
// 32x64 register file, two combinational read ports, one write port; x0 reads as zero.
module rr_regfile
    import register_read_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_NUM_W-1:0] rd0_num,
    input  logic [REG_NUM_W-1:0] rd1_num,
    output logic [XLEN-1:0]      rd0_data,
    output logic [XLEN-1:0]      rd1_data,
    input  logic                 wr_en,
    input  logic [REG_NUM_W-1:0] wr_num,
    input  logic [XLEN-1:0]      wr_data
);
    logic [XLEN-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en && wr_num != '0) begin
            regs[wr_num] <= wr_data;
        end
    end

    assign rd0_data = (rd0_num == '0) ? '0 : regs[rd0_num];
    assign rd1_data = (rd1_num == '0) ? '0 : regs[rd1_num];
endmodule

// File: rtl/register_read.sv
// Register-read stage: regfile, busy scoreboard, immediate extension, issue register.
// Define RR_WB_BYPASS_EN to forward same-cycle writeback data and skip the extra stall.
module register_read
    import register_read_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rr_is_inst_valid,
    input  logic [XLEN-1:0]      rr_pc,
    input  logic [31:0]          rr_instrux,
    input  logic [REG_NUM_W-1:0] rr_read_reg0_num,
    input  logic [REG_NUM_W-1:0] rr_read_reg1_num,
    input  logic [REG_NUM_W-1:0] rr_write_reg_num,
    input  logic [XLEN-1:0]      rr_imm,
    input  logic [OP_W-1:0]      rr_operation,
    input  logic                 rr_is_inst_regwrite,
    input  logic                 rr_is_inst_memread,
    input  logic                 rr_is_inst_memwrite,
    input  logic                 wb_en,
    input  logic [REG_NUM_W-1:0] wb_reg_num,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 ex_stall,
    output logic                 orr_hazard_stall,
    output logic                 orr_is_inst_valid,
    output logic [XLEN-1:0]      orr_pc,
    output logic [31:0]          orr_instrux,
    output logic [XLEN-1:0]      orr_rs0_val,
    output logic [XLEN-1:0]      orr_rs1_val,
    output logic [XLEN-1:0]      orr_imm,
    output logic [REG_NUM_W-1:0] orr_write_reg_num,
    output logic [OP_W-1:0]      orr_operation,
    output logic                 orr_is_inst_regwrite,
    output logic                 orr_is_inst_memread,
    output logic                 orr_is_inst_memwrite
);
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next, eff_busy, set_mask, clr_mask;
    logic [XLEN-1:0]     rf_rd0, rf_rd1, rs0_val, rs1_val, imm_ext;
    logic                hazard, issue;
    imm_kind_e           kind;
    logic                unused_imm_hi;

    assign unused_imm_hi = ^rr_imm[XLEN-1:21];

    rr_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd0_num  (rr_read_reg0_num),
        .rd1_num  (rr_read_reg1_num),
        .rd0_data (rf_rd0),
        .rd1_data (rf_rd1),
        .wr_en    (wb_en),
        .wr_num   (wb_reg_num),
        .wr_data  (wb_data)
    );

    always_comb begin
        clr_mask = '0;
        if (wb_en && wb_reg_num != '0) clr_mask[wb_reg_num] = 1'b1;
`ifdef RR_WB_BYPASS_EN
        eff_busy = busy & ~clr_mask;
        rs0_val  = (clr_mask[rr_read_reg0_num]) ? wb_data : rf_rd0;
        rs1_val  = (clr_mask[rr_read_reg1_num]) ? wb_data : rf_rd1;
`else
        // A register freed this cycle still stalls; the value is read next cycle.
        eff_busy = busy;
        rs0_val  = rf_rd0;
        rs1_val  = rf_rd1;
`endif
        hazard = rr_is_inst_valid &&
                 ((rr_read_reg0_num != '0 && eff_busy[rr_read_reg0_num]) ||
                  (rr_read_reg1_num != '0 && eff_busy[rr_read_reg1_num]) ||
                  (rr_is_inst_regwrite && rr_write_reg_num != '0 && eff_busy[rr_write_reg_num]));
        issue  = rr_is_inst_valid && !hazard && !ex_stall;
        orr_hazard_stall = hazard || ex_stall;

        set_mask = '0;
        if (issue && rr_is_inst_regwrite && rr_write_reg_num != '0)
            set_mask[rr_write_reg_num] = 1'b1;
        // Set is applied after clear so a same-cycle set wins.
        busy_next = (busy & ~clr_mask) | set_mask;
    end

    always_comb begin
        kind = imm_kind(rr_instrux);
        case (kind)
            IMM_I, IMM_S: imm_ext = {{(XLEN-12){rr_imm[11]}}, rr_imm[11:0]};
            IMM_B:        imm_ext = {{(XLEN-13){rr_imm[11]}}, rr_imm[11:0], 1'b0};
            IMM_J:        imm_ext = {{(XLEN-21){rr_imm[20]}}, rr_imm[20:0]};
            IMM_U:        imm_ext = {{(XLEN-32){rr_imm[19]}}, rr_imm[19:0], 12'h000};
            IMM_SHAMT:    imm_ext = {{(XLEN-6){1'b0}}, rr_imm[5:0]};
            default:      imm_ext = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy                 <= '0;
            orr_is_inst_valid    <= 1'b0;
            orr_pc               <= '0;
            orr_instrux          <= '0;
            orr_rs0_val          <= '0;
            orr_rs1_val          <= '0;
            orr_imm              <= '0;
            orr_write_reg_num    <= '0;
            orr_operation        <= '0;
            orr_is_inst_regwrite <= 1'b0;
            orr_is_inst_memread  <= 1'b0;
            orr_is_inst_memwrite <= 1'b0;
        end else begin
            busy <= busy_next;
            if (!ex_stall) begin
                orr_is_inst_valid    <= issue;
                orr_pc               <= issue ? rr_pc : '0;
                orr_instrux          <= issue ? rr_instrux : '0;
                orr_rs0_val          <= issue ? rs0_val : '0;
                orr_rs1_val          <= issue ? rs1_val : '0;
                orr_imm              <= issue ? imm_ext : '0;
                orr_write_reg_num    <= issue ? rr_write_reg_num : '0;
                orr_operation        <= issue ? rr_operation : '0;
                orr_is_inst_regwrite <= issue && rr_is_inst_regwrite;
                orr_is_inst_memread  <= issue && rr_is_inst_memread;
                orr_is_inst_memwrite <= issue && rr_is_inst_memwrite;
            end
        end
    end
endmodule

// File: doc/register_read.md
REGISTER_READ -- requirements
Module: register_read

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL accept from decode: rr_is_inst_valid 1, rr_pc 64, rr_instrux 32, rr_read_reg0_num 5, rr_read_reg1_num 5, rr_write_reg_num 5, rr_imm 64 (raw field, unextended), rr_operation 11, rr_is_inst_regwrite 1, rr_is_inst_memread 1, rr_is_inst_memwrite 1.
REQ-004 SHALL accept writeback: wb_en 1, wb_reg_num 5, wb_data 64.
REQ-005 SHALL accept ex_stall input 1, meaning execute cannot take a new instruction.
REQ-006 SHALL output orr_hazard_stall output 1, meaning decode must hold its current instruction.
REQ-007 SHALL output to execute: orr_is_inst_valid 1, orr_pc 64, orr_instrux 32, orr_rs0_val 64, orr_rs1_val 64, orr_imm 64 (sign-extended), orr_write_reg_num 5, orr_operation 11, orr_is_inst_regwrite 1, orr_is_inst_memread 1, orr_is_inst_memwrite 1.

Function
REQ-008 SHALL contain a 32x64 register file: two combinational read ports and one write port, written on a clock edge when wb_en=1 and wb_reg_num!=0.
REQ-009 SHALL return 0 for any read of x0; writes to x0 are ignored.
REQ-010 SHALL keep a 32-bit busy scoreboard. A bit is set when a valid regwrite instruction with rd!=0 issues to execute. It is cleared on wb_en for that register.
REQ-011 When a set and a clear hit the same register in one cycle, the set SHALL win.
REQ-012 SHALL assert orr_hazard_stall combinationally when rr_is_inst_valid=1 and any of these holds:
- a used source (nonzero read_reg num) is busy and not being cleared this cycle;
- the destination is busy and not being cleared (WAW).
REQ-013 Issue SHALL occur when rr_is_inst_valid=1, orr_hazard_stall=0 and ex_stall=0. The output registers are loaded with operands, sign-extended immediate and pass-through fields, with 1-cycle latency.
REQ-014 When ex_stall=1, all orr_* registers SHALL hold and the scoreboard SHALL NOT set.
REQ-015 When ex_stall=0 and there is a hazard or no valid input, the stage SHALL emit a bubble: orr_is_inst_valid=0, regwrite/memread/memwrite=0, other outputs 0.
REQ-016 orr_hazard_stall SHALL also assert while ex_stall=1, so decode holds.
REQ-017 Immediate extension SHALL be selected by rr_instrux[6:0]:
- 0x13, 0x1b, 0x03, 0x67, 0x23: sign-extend from bit 11;
- 0x63: sign-extend from bit 11, then shift left 1;
- 0x6f: sign-extend from bit 20 (value already doubled);
- 0x37, 0x17: imm<<12, sign-extended from bit 31;
- 0x33, 0x3b, 0x73 and others: zero.
REQ-018 Shift immediates (funct3 1 or 5 under 0x13/0x1b) SHALL pass through unextended, masked to 6 bits.

Reset
REQ-019 On rst_n=0, asynchronously and independent of clk, the stage SHALL clear all orr_* outputs, all scoreboard bits and all 32 registers to 0.
REQ-020 An instruction in flight at reset SHALL be discarded. The first issue can occur on the first rising edge after rst_n deasserts.

Configuration
REQ-021 Macro RR_WB_BYPASS_EN defined: when wb_en matches a source this cycle, orr_rs*_val SHALL take wb_data, and the matching busy bit is treated as clear for hazard checks. There is no stall.
REQ-022 RR_WB_BYPASS_EN undefined: a busy bit being cleared this cycle SHALL still count as busy, giving one extra stall cycle. Operands are always read from the register file after the write.

Structure
REQ-023 The shared package SHALL hold:
- XLEN=64, REG_NUM_W=5, NUM_REGS=32;
- opcode constants for the REQ-017 classes;
- an imm_kind_e enum (I, S, B, J, U, SHAMT, NONE).
REQ-024 The register file SHALL be a sub-module rr_regfile (2R1W, async reset). The scoreboard, immediate extender and pipeline register SHALL live in register_read.

Verification
REQ-025 Reset then issue addi x5,x0,-1 (0xfff00293) SHALL produce, next cycle, orr_imm=0xffffffffffffffff, orr_rs0_val=0, valid=1, busy[5]=1.
REQ-026 With busy[5]=1, issue add x6,x5,x5 SHALL produce orr_hazard_stall=1 and a bubble. Then wb_en=1, wb_reg_num=5, wb_data=0x1234:
- with bypass: issues that cycle with rs0=rs1=0x1234;
- without bypass: issues one cycle later.
REQ-027 With ex_stall held 3 cycles during a valid issue, outputs SHALL be unchanged, orr_hazard_stall=1, and the busy bits unchanged.
REQ-028 lui x7,0x80000 SHALL produce orr_imm=0xffffffff80000000. beq with raw imm 0x800 SHALL produce 0xfffffffffffff000.
REQ-029 wb_en to x0 with wb_data=0xdead, then a read of x0, SHALL return 0.
REQ-030 Asserting rst_n=0 mid-stall with busy[5]=1 SHALL immediately set orr_is_inst_valid=0 and clear all busy bits.
